// File: rtl/csr_regs_pkg.sv
// Shared CSR address map and field positions for csr_regs.
// minstret is only mapped when CSR_MINSTRET_EN is defined.
package csr_regs_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE_BIT = 3;

  function automatic logic csr_mapped(input logic [11:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE: hit = 1'b1;
`ifdef CSR_MINSTRET_EN
      CSR_MINSTRET: hit = 1'b1;
`endif
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_regs_counter.sv
// 64-bit free-running counter with synchronous load; load wins over increment
// and reset wins over both.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        load_en,
  input  logic [63:0] load_data,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load_en) begin
      count <= load_data;
    end else if (inc_en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regs.sv
// Machine-mode CSR file with two write/read ports (ex stage and interrupt
// controller). Optional minstret counter is built when CSR_MINSTRET_EN is defined.
module csr_regs
  import csr_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [63:0] waddr_i,
  input  logic [63:0] raddr_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  input  logic        clint_we_i,
  input  logic [63:0] clint_waddr_i,
  input  logic [63:0] clint_raddr_i,
  input  logic [63:0] clint_data_i,
  output logic [63:0] clint_data_o,
  output logic [63:0] clint_csr_mtvec,
  output logic [63:0] clint_csr_mepc,
  output logic [63:0] clint_csr_mstatus,
  output logic        global_int_en_o,
  input  logic        inst_retire_i
);

  logic [11:0] ex_waddr;
  logic [11:0] ex_raddr;
  logic [11:0] cl_waddr;
  logic [11:0] cl_raddr;

  assign ex_waddr = waddr_i[11:0];
  assign ex_raddr = raddr_i[11:0];
  assign cl_waddr = clint_waddr_i[11:0];
  assign cl_raddr = clint_raddr_i[11:0];

  logic [63:0] mstatus_q;
  logic [63:0] mie_q;
  logic [63:0] mtvec_q;
  logic [63:0] mscratch_q;
  logic [63:0] mepc_q;
  logic [63:0] mcause_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  // The ex port always wins when both ports target the same CSR.
  function automatic logic wr_en(input logic [11:0] addr);
    return (we_i && (ex_waddr == addr)) || (clint_we_i && (cl_waddr == addr));
  endfunction

  function automatic logic [63:0] wr_data(input logic [11:0] addr);
    return (we_i && (ex_waddr == addr)) ? data_i : clint_data_i;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (wr_en(CSR_MSTATUS))  mstatus_q  <= wr_data(CSR_MSTATUS);
      if (wr_en(CSR_MIE))      mie_q      <= wr_data(CSR_MIE);
      if (wr_en(CSR_MTVEC))    mtvec_q    <= wr_data(CSR_MTVEC);
      if (wr_en(CSR_MSCRATCH)) mscratch_q <= wr_data(CSR_MSCRATCH);
      if (wr_en(CSR_MEPC))     mepc_q     <= wr_data(CSR_MEPC);
      if (wr_en(CSR_MCAUSE))   mcause_q   <= wr_data(CSR_MCAUSE);
    end
  end

  logic        mcycle_load;
  logic [63:0] mcycle_load_data;

  assign mcycle_load      = wr_en(CSR_MCYCLE);
  assign mcycle_load_data = wr_data(CSR_MCYCLE);

  csr_counter u_mcycle (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (1'b1),
    .load_en   (mcycle_load),
    .load_data (mcycle_load_data),
    .count     (mcycle_q)
  );

`ifdef CSR_MINSTRET_EN
  logic        minstret_load;
  logic [63:0] minstret_load_data;

  assign minstret_load      = wr_en(CSR_MINSTRET);
  assign minstret_load_data = wr_data(CSR_MINSTRET);

  csr_counter u_minstret (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (inst_retire_i),
    .load_en   (minstret_load),
    .load_data (minstret_load_data),
    .count     (minstret_q)
  );

  logic unused_bits;
  assign unused_bits = ^{waddr_i[63:12], raddr_i[63:12],
                         clint_waddr_i[63:12], clint_raddr_i[63:12]};
`else
  assign minstret_q = '0;

  logic unused_bits;
  assign unused_bits = ^{waddr_i[63:12], raddr_i[63:12],
                         clint_waddr_i[63:12], clint_raddr_i[63:12],
                         inst_retire_i, minstret_q};
`endif

  function automatic logic [63:0] stored(input logic [11:0] addr);
    logic [63:0] val;
    val = '0;
    case (addr)
      CSR_MSTATUS:  val = mstatus_q;
      CSR_MIE:      val = mie_q;
      CSR_MTVEC:    val = mtvec_q;
      CSR_MSCRATCH: val = mscratch_q;
      CSR_MEPC:     val = mepc_q;
      CSR_MCAUSE:   val = mcause_q;
      CSR_MCYCLE:   val = mcycle_q;
`ifdef CSR_MINSTRET_EN
      CSR_MINSTRET: val = minstret_q;
`endif
      default:      val = '0;
    endcase
    return val;
  endfunction

  // Same-cycle write data is forwarded so readers never see a stale CSR.
  function automatic logic [63:0] read_csr(input logic [11:0] addr);
    logic [63:0] val;
    if (!csr_mapped(addr)) begin
      val = '0;
    end else if (we_i && (ex_waddr == addr)) begin
      val = data_i;
    end else if (clint_we_i && (cl_waddr == addr)) begin
      val = clint_data_i;
    end else begin
      val = stored(addr);
    end
    return val;
  endfunction

  assign data_o       = read_csr(ex_raddr);
  assign clint_data_o = read_csr(cl_raddr);

  assign clint_csr_mtvec   = mtvec_q;
  assign clint_csr_mepc    = mepc_q;
  assign clint_csr_mstatus = mstatus_q;
  assign global_int_en_o   = mstatus_q[MSTATUS_MIE_BIT];

endmodule

// File: tb/tb_csr_regs.sv
// Self-checking bench for csr_regs: directed vector table, hand sequences for
// counter/reset corners, and randomized traffic against an address-keyed model.
module tb_csr_regs;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [63:0] waddr_i;
  logic [63:0] raddr_i;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic        clint_we_i;
  logic [63:0] clint_waddr_i;
  logic [63:0] clint_raddr_i;
  logic [63:0] clint_data_i;
  logic [63:0] clint_data_o;
  logic [63:0] clint_csr_mtvec;
  logic [63:0] clint_csr_mepc;
  logic [63:0] clint_csr_mstatus;
  logic        global_int_en_o;
  logic        inst_retire_i;

  csr_regs dut (
    .clk               (clk),
    .rst               (rst),
    .we_i              (we_i),
    .waddr_i           (waddr_i),
    .raddr_i           (raddr_i),
    .data_i            (data_i),
    .data_o            (data_o),
    .clint_we_i        (clint_we_i),
    .clint_waddr_i     (clint_waddr_i),
    .clint_raddr_i     (clint_raddr_i),
    .clint_data_i      (clint_data_i),
    .clint_data_o      (clint_data_o),
    .clint_csr_mtvec   (clint_csr_mtvec),
    .clint_csr_mepc    (clint_csr_mepc),
    .clint_csr_mstatus (clint_csr_mstatus),
    .global_int_en_o   (global_int_en_o),
    .inst_retire_i     (inst_retire_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

`ifdef CSR_MINSTRET_EN
  localparam bit MINSTRET_ON = 1'b1;
`else
  localparam bit MINSTRET_ON = 1'b0;
`endif

  // ---------------- reference model ----------------
  // One entry per implemented CSR; absence of a key means unmapped.
  logic [63:0] model[int];

  function automatic void model_clear();
    model.delete();
    model[32'h300] = '0;
    model[32'h304] = '0;
    model[32'h305] = '0;
    model[32'h340] = '0;
    model[32'h341] = '0;
    model[32'h342] = '0;
    model[32'hB00] = '0;
    if (MINSTRET_ON) model[32'hB02] = '0;
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] addr);
    int a;
    a = int'(addr[11:0]);
    if (!model.exists(a)) return '0;
    if (we_i && int'(waddr_i[11:0]) == a) return data_i;
    if (clint_we_i && int'(clint_waddr_i[11:0]) == a) return clint_data_i;
    return model[a];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_commit();
    int wa;
    int ca;
    if (rst) begin
      model_clear();
      return;
    end
    model[32'hB00] = model[32'hB00] + 64'd1;
    if (MINSTRET_ON && inst_retire_i) model[32'hB02] = model[32'hB02] + 64'd1;
    wa = int'(waddr_i[11:0]);
    ca = int'(clint_waddr_i[11:0]);
    if (clint_we_i && model.exists(ca)) model[ca] = clint_data_i;
    if (we_i && model.exists(wa)) model[wa] = data_i;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic we, input logic [63:0] wa, input logic [63:0] ra,
                       input logic [63:0] d, input logic cwe, input logic [63:0] cwa,
                       input logic [63:0] cra, input logic [63:0] cd, input logic ret);
    we_i          = we;
    waddr_i       = wa;
    raddr_i       = ra;
    data_i        = d;
    clint_we_i    = cwe;
    clint_waddr_i = cwa;
    clint_raddr_i = cra;
    clint_data_i  = cd;
    inst_retire_i = ret;
  endtask

  task automatic idle(input logic [63:0] ra, input logic [63:0] cra);
    drive(1'b0, '0, ra, '0, 1'b0, '0, cra, '0, 1'b0);
  endtask

  // Check all outputs against the model, then clock once and update the model.
  task automatic cycle();
    #1;
    check("data_o",       data_o,            model_read(raddr_i));
    check("clint_data_o", clint_data_o,      model_read(clint_raddr_i));
    check("mtvec_out",    clint_csr_mtvec,   model[32'h305]);
    check("mepc_out",     clint_csr_mepc,    model[32'h341]);
    check("mstatus_out",  clint_csr_mstatus, model[32'h300]);
    check("gie",          {63'd0, global_int_en_o}, {63'd0, model[32'h300][3]});
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [63:0] wa;
    logic [63:0] ra;
    logic [63:0] d;
    logic        cwe;
    logic [63:0] cwa;
    logic [63:0] cra;
    logic [63:0] cd;
    logic [63:0] exp_data;
    logic [63:0] exp_cdata;
    logic        exp_gie;
  } vec_t;

  vec_t tbl[9];

  logic [63:0] rand_addrs[10];

  initial begin
    rst = 1'b1;
    idle('0, '0);
    @(posedge clk);
    model_clear();
    #1;

    // Reset state: every output zero while and after reset.
    do_reset(2);
    idle(64'h300, 64'h305);
    #1;
    check("reset_mstatus", data_o, 64'd0);
    check("reset_mtvec",   clint_data_o, 64'd0);
    check("reset_gie",     {63'd0, global_int_en_o}, 64'd0);

    // Idle 10 cycles after reset: mcycle counts 10 edges.
    for (int i = 0; i < 10; i++) cycle();
    idle(64'hB00, 64'h342);
    #1;
    check("mcycle_after_10", data_o, 64'd10);
    check("mcause_idle",     clint_data_o, 64'd0);
    cycle();

    // Directed table, starting from a clean reset.
    tbl[0] = '{1'b1, 64'h300, 64'h300, 64'h8, 1'b0, 64'h0, 64'h300, 64'h0, 64'h8, 64'h8, 1'b0};
    tbl[1] = '{1'b0, 64'h0, 64'h300, 64'h0, 1'b0, 64'h0, 64'h304, 64'h0, 64'h8, 64'h0, 1'b1};
    tbl[2] = '{1'b1, 64'h341, 64'h341, 64'h100, 1'b1, 64'h341, 64'h341, 64'h200, 64'h100, 64'h100, 1'b1};
    tbl[3] = '{1'b0, 64'h0, 64'h341, 64'h0, 1'b0, 64'h0, 64'h342, 64'h0, 64'h100, 64'h0, 1'b1};
    tbl[4] = '{1'b1, 64'h341, 64'h342, 64'h55, 1'b1, 64'h342, 64'h341, 64'd11, 64'd11, 64'h55, 1'b1};
    tbl[5] = '{1'b0, 64'h0, 64'h342, 64'h0, 1'b0, 64'h0, 64'h341, 64'h0, 64'd11, 64'h55, 1'b1};
    tbl[6] = '{1'b1, 64'h123, 64'h123, 64'hDEAD, 1'b0, 64'h0, 64'h305, 64'h0, 64'h0, 64'h0, 1'b1};
    tbl[7] = '{1'b1, 64'hFFFF_0000_0000_1305, 64'h7305, 64'hABCD, 1'b0, 64'h0, 64'h340, 64'h0,
               64'hABCD, 64'h0, 1'b1};
    tbl[8] = '{1'b0, 64'h0, 64'h305, 64'h0, 1'b0, 64'h0, 64'h1305, 64'h0, 64'hABCD, 64'hABCD, 1'b1};

    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].ra, tbl[i].d, tbl[i].cwe, tbl[i].cwa,
            tbl[i].cra, tbl[i].cd, 1'b0);
      #1;
      check($sformatf("vec%0d_data", i),  data_o, tbl[i].exp_data);
      check($sformatf("vec%0d_cdata", i), clint_data_o, tbl[i].exp_cdata);
      check($sformatf("vec%0d_gie", i),   {63'd0, global_int_en_o}, {63'd0, tbl[i].exp_gie});
      cycle();
    end
    idle(64'h0, 64'h0);
    #1;
    check("mepc_port_after_tbl", clint_csr_mepc, 64'h55);
    check("mtvec_port_after_tbl", clint_csr_mtvec, 64'hABCD);

    // mcycle wrap: load ...FFFE, then FFFF, then 0.
    drive(1'b1, 64'hB00, 64'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0, 64'hB00, 64'h0, 1'b0);
    #1;
    check("mcycle_load_bypass", data_o, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    idle(64'hB00, 64'hB00);
    #1;
    check("mcycle_fffe", data_o, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    #1;
    check("mcycle_ffff", data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
    #1;
    check("mcycle_wrap", data_o, 64'h0);
    cycle();

    // minstret: 5 retirements after reset.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 64'hB02, '0, 1'b0, '0, 64'hB00, '0, 1'b1);
      cycle();
    end
    idle(64'hB02, 64'hB02);
    #1;
    check("minstret_5", data_o, MINSTRET_ON ? 64'd5 : 64'd0);
    cycle();

    // Reset in the middle of traffic while writing mtvec.
    drive(1'b1, 64'h305, 64'h305, 64'h1234, 1'b0, '0, 64'hB00, '0, 1'b1);
    cycle();
    rst = 1'b1;
    drive(1'b1, 64'h305, 64'h300, 64'h5678, 1'b0, '0, 64'hB00, '0, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
    idle(64'hB00, 64'hB02);
    #1;
    check("rst_mtvec_port", clint_csr_mtvec, 64'h0);
    check("rst_mcycle",     data_o, 64'h0);
    check("rst_minstret",   clint_data_o, 64'h0);
    cycle();

    // Randomized traffic against the model.
    rand_addrs = '{64'h300, 64'h304, 64'h305, 64'h340, 64'h341,
                   64'h342, 64'hB00, 64'hB02, 64'h123, 64'h7FF};
    for (int i = 0; i < 400; i++) begin
      logic [63:0] wa;
      logic [63:0] ca;
      logic [63:0] hi;
      hi = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_F000;
      wa = rand_addrs[$urandom_range(0, 9)] | hi;
      ca = ($urandom_range(0, 3) == 0) ? wa : rand_addrs[$urandom_range(0, 9)];
      drive(1'($urandom_range(0, 1)), wa,
            rand_addrs[$urandom_range(0, 9)] | hi, {$urandom, $urandom},
            1'($urandom_range(0, 1)), ca, rand_addrs[$urandom_range(0, 9)],
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/csr_regs.md
CSR_REGS -- requirements
Module: csr_regs

Interface
REQ-001 SHALL have port clk  input  1  single core clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port we_i  input  1  ex-stage CSR write enable.
REQ-004 SHALL have port waddr_i  input  64  ex-stage CSR write address.
REQ-005 SHALL have port raddr_i  input  64  ex-stage CSR read address.
REQ-006 SHALL have port data_i  input  64  ex-stage CSR write data.
REQ-007 SHALL have port data_o  output  64  ex-stage CSR read data.
REQ-008 SHALL have port clint_we_i  input  1  interrupt-controller write enable.
REQ-009 SHALL have port clint_waddr_i  input  64  interrupt-controller write address.
REQ-010 SHALL have port clint_raddr_i  input  64  interrupt-controller read address.
REQ-011 SHALL have port clint_data_i  input  64  interrupt-controller write data.
REQ-012 SHALL have port clint_data_o  output  64  interrupt-controller read data.
REQ-013 SHALL have port clint_csr_mtvec  output  64  mtvec register value.
REQ-014 SHALL have port clint_csr_mepc  output  64  mepc register value.
REQ-015 SHALL have port clint_csr_mstatus  output  64  mstatus register value.
REQ-016 SHALL have port global_int_en_o  output  1  mstatus.MIE (bit 3).
REQ-017 SHALL have port inst_retire_i  input  1  one instruction retired this cycle.

Function
REQ-018 SHALL implement 64-bit mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02.
REQ-019 SHALL decode only address bits [11:0]; bits [63:12] ignored.
REQ-020 SHALL ignore writes to unmapped addresses; unmapped reads return 0.
REQ-021 SHALL commit writes at the clock edge where the enable is sampled high, storing the full 64-bit data unmodified.
REQ-022 SHALL commit both ports in one cycle when both write enables are high and addresses differ.
REQ-023 SHALL, on same-address simultaneous writes, commit ex-port data and discard the interrupt-controller data.
REQ-024 SHALL drive data_o and clint_data_o combinationally (zero-latency) from the read address.
REQ-025 SHALL bypass: a read matching a same-cycle write address returns that write data (ex data when both ports match).
REQ-026 SHALL drive clint_csr_mtvec/mepc/mstatus and global_int_en_o from stored registers only (no bypass; new value visible the cycle after the write).
REQ-027 SHALL increment mcycle by 1 every cycle out of reset, wrapping 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-028 SHALL, on a write to mcycle, load the written value and skip that cycle's increment.
REQ-029 SHALL treat minstret per REQ-027/028 but increment only when inst_retire_i is high.

Reset
REQ-030 SHALL clear every CSR, including mcycle and minstret, to 0 while rst is high; all outputs read 0 the cycle after.
REQ-031 SHALL give rst priority over any concurrent write or increment; the first increment occurs at the first edge with rst low.

Configuration
REQ-032 SHALL compile minstret only when CSR_MINSTRET_EN is defined; without it, 0xB02 is unmapped (reads 0, writes ignored) and inst_retire_i is unused but the port remains.

Structure
REQ-033 SHALL take CSR address constants (12-bit) and the MIE bit index from the shared defines package.
REQ-034 SHALL implement mcycle/minstret as one sub-module csr_counter (64-bit counter with increment enable, load enable, load data), instantiated once or twice.

Verification
REQ-035 Reset, idle 10 cycles -> mcycle reads 10 (±1 per defined edge count), all other CSRs read 0, global_int_en_o=0.
REQ-036 ex writes 0x300 <- 0x8 -> data_o=0x8 same cycle (bypass); global_int_en_o=1 next cycle.
REQ-037 ex writes 0x341 <- 0x100 and clint writes 0x341 <- 0x200 same cycle -> mepc=0x100; clint writes 0x342 <- 11 with ex writing 0x341 -> both committed.
REQ-038 write mcycle <- 0xFFFF_FFFF_FFFF_FFFE -> reads ...FFFE, then ...FFFF, then 0 on successive cycles.
REQ-039 inst_retire_i high 5 cycles -> minstret=5 with CSR_MINSTRET_EN; minstret reads 0 without it.
REQ-040 rst asserted mid-sequence with we_i high to 0x305 -> mtvec stays 0, counters 0.
